// File: rtl/cache_bus_arbiter_pkg.sv
// Shared widths, read-FSM encoding and requester IDs for the cache bus arbiter.
package cache_bus_arbiter_pkg;

    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned LINE_BEATS = 2;

    // Read-channel ownership states
    typedef enum logic [1:0] {
        R_IDLE   = 2'b00,
        R_ICACHE = 2'b01,
        R_DCACHE = 2'b10
    } r_state_e;

    // Requester identities, also used to remember who was served last
    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } req_id_e;

endpackage

// File: rtl/cache_bus_arbiter.sv
// Shares the memory-side read channel between ICache and DCache with round-robin
// burst arbitration, passes the DCache write-back channel straight through, and
// holds off ICache refills while a write-back is still unacknowledged.
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,

    input  logic              io_icache_r_valid,
    input  logic [ADDR_W-1:0] io_icache_r_bits_raddr,
    output logic [DATA_W-1:0] io_icache_r_bits_rdata,
    output logic              io_icache_r_bits_rlast,
    output logic              io_icache_r_ready,

    input  logic              io_dcache_r_valid,
    input  logic [ADDR_W-1:0] io_dcache_r_bits_raddr,
    output logic [DATA_W-1:0] io_dcache_r_bits_rdata,
    output logic              io_dcache_r_bits_rlast,
    output logic              io_dcache_r_ready,

    input  logic              io_dcache_w_valid,
    input  logic [ADDR_W-1:0] io_dcache_w_bits_waddr,
    input  logic [DATA_W-1:0] io_dcache_w_bits_wdata,
    input  logic              io_dcache_w_bits_wlast,
    output logic              io_dcache_w_ready,

    output logic              io_dcache_b_valid,
    input  logic              io_dcache_b_ready,

    output logic              io_mem_r_valid,
    output logic [ADDR_W-1:0] io_mem_r_bits_raddr,
    input  logic [DATA_W-1:0] io_mem_r_bits_rdata,
    input  logic              io_mem_r_bits_rlast,
    input  logic              io_mem_r_ready,

    output logic              io_mem_w_valid,
    output logic [ADDR_W-1:0] io_mem_w_bits_waddr,
    output logic [DATA_W-1:0] io_mem_w_bits_wdata,
    output logic              io_mem_w_bits_wlast,
    input  logic              io_mem_w_ready,

    input  logic              io_mem_b_valid,
    output logic              io_mem_b_ready
);

    r_state_e state;
    r_state_e state_next;
    req_id_e  last_grant;
    req_id_e  last_grant_next;
    logic     wb_pending;
    logic     wb_pending_next;
    logic     icache_cand;
    logic     dcache_cand;
    logic     w_fire;
    logic     b_fire;

    // State, fairness pointer and write-back tracker
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= R_IDLE;
            last_grant <= DCACHE;
            wb_pending <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            wb_pending <= wb_pending_next;
        end
    end

    // A new write burst starting in the same cycle as a response keeps the block up
    always_comb begin
        w_fire          = io_dcache_w_valid & io_mem_w_ready;
        b_fire          = io_mem_b_valid & io_dcache_b_ready;
        wb_pending_next = wb_pending;
        if (w_fire) begin
            wb_pending_next = 1'b1;
        end else if (b_fire) begin
            wb_pending_next = 1'b0;
        end
    end

    // Read arbitration: grant whole bursts, release on the rlast beat
    always_comb begin
        state_next          = state;
        last_grant_next     = last_grant;
        io_mem_r_valid      = 1'b0;
        io_mem_r_bits_raddr = '0;
        io_icache_r_ready   = 1'b0;
        io_dcache_r_ready   = 1'b0;
        icache_cand         = io_icache_r_valid & ~wb_pending;
        dcache_cand         = io_dcache_r_valid;

        case (state)
            R_IDLE: begin
                if (icache_cand && dcache_cand) begin
                    state_next = (last_grant == ICACHE) ? R_DCACHE : R_ICACHE;
                end else if (icache_cand) begin
                    state_next = R_ICACHE;
                end else if (dcache_cand) begin
                    state_next = R_DCACHE;
                end
            end
            R_ICACHE: begin
                io_mem_r_valid      = io_icache_r_valid;
                io_mem_r_bits_raddr = io_icache_r_bits_raddr;
                io_icache_r_ready   = io_mem_r_ready;
                if (io_icache_r_valid && io_mem_r_ready && io_mem_r_bits_rlast) begin
                    state_next      = R_IDLE;
                    last_grant_next = ICACHE;
                end
            end
            R_DCACHE: begin
                io_mem_r_valid      = io_dcache_r_valid;
                io_mem_r_bits_raddr = io_dcache_r_bits_raddr;
                io_dcache_r_ready   = io_mem_r_ready;
                if (io_dcache_r_valid && io_mem_r_ready && io_mem_r_bits_rlast) begin
                    state_next      = R_IDLE;
                    last_grant_next = DCACHE;
                end
            end
            default: begin
                state_next = R_IDLE;
            end
        endcase
    end

    // Read data is broadcast; each cache qualifies it with its own r_ready
    assign io_icache_r_bits_rdata = io_mem_r_bits_rdata;
    assign io_icache_r_bits_rlast = io_mem_r_bits_rlast;
    assign io_dcache_r_bits_rdata = io_mem_r_bits_rdata;
    assign io_dcache_r_bits_rlast = io_mem_r_bits_rlast;

    // Write-back and response channels pass straight through
    assign io_mem_w_valid      = io_dcache_w_valid;
    assign io_mem_w_bits_waddr = io_dcache_w_bits_waddr;
    assign io_mem_w_bits_wdata = io_dcache_w_bits_wdata;
    assign io_mem_w_bits_wlast = io_dcache_w_bits_wlast;
    assign io_dcache_w_ready   = io_mem_w_ready;
    assign io_dcache_b_valid   = io_mem_b_valid;
    assign io_mem_b_ready      = io_dcache_b_ready;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Randomised bench for cache_bus_arbiter: beat scoreboards per cache plus a
// burst-level ownership model checked every cycle.
module tb_cache_bus_arbiter;
    import cache_bus_arbiter_pkg::*;

    localparam int RUN_CYCLES = 4000;
    localparam int DRAIN_MAX  = 400;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_icache_r_valid;
    logic [ADDR_W-1:0] io_icache_r_bits_raddr;
    logic [DATA_W-1:0] io_icache_r_bits_rdata;
    logic              io_icache_r_bits_rlast;
    logic              io_icache_r_ready;
    logic              io_dcache_r_valid;
    logic [ADDR_W-1:0] io_dcache_r_bits_raddr;
    logic [DATA_W-1:0] io_dcache_r_bits_rdata;
    logic              io_dcache_r_bits_rlast;
    logic              io_dcache_r_ready;
    logic              io_dcache_w_valid;
    logic [ADDR_W-1:0] io_dcache_w_bits_waddr;
    logic [DATA_W-1:0] io_dcache_w_bits_wdata;
    logic              io_dcache_w_bits_wlast;
    logic              io_dcache_w_ready;
    logic              io_dcache_b_valid;
    logic              io_dcache_b_ready;
    logic              io_mem_r_valid;
    logic [ADDR_W-1:0] io_mem_r_bits_raddr;
    logic [DATA_W-1:0] io_mem_r_bits_rdata;
    logic              io_mem_r_bits_rlast;
    logic              io_mem_r_ready;
    logic              io_mem_w_valid;
    logic [ADDR_W-1:0] io_mem_w_bits_waddr;
    logic [DATA_W-1:0] io_mem_w_bits_wdata;
    logic              io_mem_w_bits_wlast;
    logic              io_mem_w_ready;
    logic              io_mem_b_valid;
    logic              io_mem_b_ready;

    always #5 clock = ~clock;

    cache_bus_arbiter dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_icache_r_valid      (io_icache_r_valid),
        .io_icache_r_bits_raddr (io_icache_r_bits_raddr),
        .io_icache_r_bits_rdata (io_icache_r_bits_rdata),
        .io_icache_r_bits_rlast (io_icache_r_bits_rlast),
        .io_icache_r_ready      (io_icache_r_ready),
        .io_dcache_r_valid      (io_dcache_r_valid),
        .io_dcache_r_bits_raddr (io_dcache_r_bits_raddr),
        .io_dcache_r_bits_rdata (io_dcache_r_bits_rdata),
        .io_dcache_r_bits_rlast (io_dcache_r_bits_rlast),
        .io_dcache_r_ready      (io_dcache_r_ready),
        .io_dcache_w_valid      (io_dcache_w_valid),
        .io_dcache_w_bits_waddr (io_dcache_w_bits_waddr),
        .io_dcache_w_bits_wdata (io_dcache_w_bits_wdata),
        .io_dcache_w_bits_wlast (io_dcache_w_bits_wlast),
        .io_dcache_w_ready      (io_dcache_w_ready),
        .io_dcache_b_valid      (io_dcache_b_valid),
        .io_dcache_b_ready      (io_dcache_b_ready),
        .io_mem_r_valid         (io_mem_r_valid),
        .io_mem_r_bits_raddr    (io_mem_r_bits_raddr),
        .io_mem_r_bits_rdata    (io_mem_r_bits_rdata),
        .io_mem_r_bits_rlast    (io_mem_r_bits_rlast),
        .io_mem_r_ready         (io_mem_r_ready),
        .io_mem_w_valid         (io_mem_w_valid),
        .io_mem_w_bits_waddr    (io_mem_w_bits_waddr),
        .io_mem_w_bits_wdata    (io_mem_w_bits_wdata),
        .io_mem_w_bits_wlast    (io_mem_w_bits_wlast),
        .io_mem_w_ready         (io_mem_w_ready),
        .io_mem_b_valid         (io_mem_b_valid),
        .io_mem_b_ready         (io_mem_b_ready)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t ic_exp[$];
    beat_t dc_exp[$];
    int    checks = 0;
    int    errors = 0;

    // Memory model: beat data is a fixed function of line address and beat index
    int mem_beat = 0;

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a, input int b);
        return {a[ADDR_W-9:0], 8'(b)} ^ 64'hA5A5_0000_0000_5A5A;
    endfunction

    assign io_mem_r_bits_rdata = data_of(io_mem_r_bits_raddr, mem_beat);
    assign io_mem_r_bits_rlast = (mem_beat == int'(LINE_BEATS) - 1);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Ownership model: 0 = nobody, 1 = ICache, 2 = DCache
    int owner  = 0;
    int served = 2;
    bit pend   = 1'b0;

    // Monitor: per-cycle output checks, scoreboard pops, model advance
    initial begin
        logic  exp_mv;
        logic  ic_ok;
        logic  dc_ok;
        beat_t e;
        forever begin
            @(negedge clock);
            exp_mv = (owner == 1) ? io_icache_r_valid : (owner == 2) ? io_dcache_r_valid : 1'b0;
            check("mem_r_valid", 64'(io_mem_r_valid), 64'(exp_mv));
            check("icache_r_ready", 64'(io_icache_r_ready), 64'(owner == 1 && io_mem_r_ready));
            check("dcache_r_ready", 64'(io_dcache_r_ready), 64'(owner == 2 && io_mem_r_ready));
            if (owner == 1)
                check("mem_raddr_i", io_mem_r_bits_raddr, io_icache_r_bits_raddr);
            else if (owner == 2)
                check("mem_raddr_d", io_mem_r_bits_raddr, io_dcache_r_bits_raddr);
            else
                check("mem_raddr_idle", io_mem_r_bits_raddr, 64'd0);
            check("w_ctl", 64'({io_mem_w_valid, io_mem_w_bits_wlast, io_dcache_w_ready,
                                io_dcache_b_valid, io_mem_b_ready}),
                  64'({io_dcache_w_valid, io_dcache_w_bits_wlast, io_mem_w_ready,
                       io_mem_b_valid, io_dcache_b_ready}));
            check("w_addr", io_mem_w_bits_waddr, io_dcache_w_bits_waddr);
            check("w_data", io_mem_w_bits_wdata, io_dcache_w_bits_wdata);

            if (io_icache_r_valid && io_icache_r_ready) begin
                if (ic_exp.size() == 0) begin
                    check("icache_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = ic_exp.pop_front();
                    check("icache_rdata", io_icache_r_bits_rdata, e.data);
                    check("icache_rlast", 64'(io_icache_r_bits_rlast), 64'(e.last));
                end
            end
            if (io_dcache_r_valid && io_dcache_r_ready) begin
                if (dc_exp.size() == 0) begin
                    check("dcache_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = dc_exp.pop_front();
                    check("dcache_rdata", io_dcache_r_bits_rdata, e.data);
                    check("dcache_rlast", 64'(io_dcache_r_bits_rlast), 64'(e.last));
                end
            end

            if (reset) begin
                owner  = 0;
                served = 2;
                pend   = 1'b0;
            end else begin
                if (owner == 0) begin
                    ic_ok = io_icache_r_valid && !pend;
                    dc_ok = io_dcache_r_valid;
                    if (ic_ok && dc_ok) owner = (served == 1) ? 2 : 1;
                    else if (ic_ok)     owner = 1;
                    else if (dc_ok)     owner = 2;
                end else if (exp_mv && io_mem_r_ready && io_mem_r_bits_rlast) begin
                    served = owner;
                    owner  = 0;
                end
                if (io_dcache_w_valid && io_mem_w_ready)       pend = 1'b1;
                else if (io_mem_b_valid && io_dcache_b_ready)  pend = 1'b0;
            end
        end
    end

    // Stimulus state
    bit ic_active  = 1'b0;
    bit dc_active  = 1'b0;
    int w_left     = 0;
    int b_out      = 0;
    int b_timer    = 0;
    int reset_hold = 0;
    int resets     = 0;

    task automatic issue(input bit is_ic, input logic [ADDR_W-1:0] a);
        beat_t e;
        for (int b = 0; b < int'(LINE_BEATS); b++) begin
            e.data = data_of(a, b);
            e.last = (b == int'(LINE_BEATS) - 1);
            if (is_ic) ic_exp.push_back(e);
            else       dc_exp.push_back(e);
        end
        if (is_ic) begin
            io_icache_r_valid      = 1'b1;
            io_icache_r_bits_raddr = a;
            ic_active              = 1'b1;
        end else begin
            io_dcache_r_valid      = 1'b1;
            io_dcache_r_bits_raddr = a;
            dc_active              = 1'b1;
        end
    endtask

    function automatic logic [ADDR_W-1:0] rand_line();
        return {32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom} & ~64'hF;
    endfunction

    // One clock of stimulus: sample fires before the edge, update inputs after it
    task automatic step(input bit allow);
        bit ic_fire, ic_last, dc_fire, dc_last, m_fire, m_last, w_fire, w_last, b_fire;
        @(negedge clock);
        ic_fire = io_icache_r_valid && io_icache_r_ready;
        ic_last = io_icache_r_bits_rlast;
        dc_fire = io_dcache_r_valid && io_dcache_r_ready;
        dc_last = io_dcache_r_bits_rlast;
        m_fire  = io_mem_r_valid && io_mem_r_ready;
        m_last  = io_mem_r_bits_rlast;
        w_fire  = io_dcache_w_valid && io_mem_w_ready;
        w_last  = io_dcache_w_bits_wlast;
        b_fire  = io_mem_b_valid && io_dcache_b_ready;
        @(posedge clock);
        #1;
        if (reset_hold > 0) begin
            reset_hold--;
            if (reset_hold == 0) reset = 1'b0;
        end
        if (m_fire) mem_beat = m_last ? 0 : mem_beat + 1;
        if (ic_fire && ic_last) begin ic_active = 1'b0; io_icache_r_valid = 1'b0; end
        if (dc_fire && dc_last) begin dc_active = 1'b0; io_dcache_r_valid = 1'b0; end

        if (w_fire) begin
            w_left--;
            io_dcache_w_bits_wdata = {$urandom, $urandom};
            if (w_last) begin
                if (b_out == 0) b_timer = $urandom_range(0, 6);
                b_out++;
            end
        end
        if (b_fire) begin
            b_out--;
            io_mem_b_valid = 1'b0;
            b_timer        = $urandom_range(0, 6);
        end
        if (!io_mem_b_valid && b_out > 0 && !b_fire) begin
            if (b_timer == 0) io_mem_b_valid = 1'b1;
            else              b_timer--;
        end

        // Reset landing on the second beat of a DCache burst
        if (allow && resets < 3 && dc_fire && !dc_last && reset_hold == 0) begin
            resets++;
            reset             = 1'b1;
            reset_hold        = 2;
            io_icache_r_valid = 1'b0;
            io_dcache_r_valid = 1'b0;
            io_dcache_w_valid = 1'b0;
            io_mem_b_valid    = 1'b0;
            ic_active         = 1'b0;
            dc_active         = 1'b0;
            w_left            = 0;
            b_out             = 0;
            mem_beat          = 0;
            ic_exp.delete();
            dc_exp.delete();
        end

        if (allow && !reset) begin
            if (!ic_active && $urandom_range(0, 3) == 0) issue(1'b1, rand_line());
            if (!dc_active && $urandom_range(0, 3) == 0) issue(1'b0, rand_line());
            if (w_left == 0 && $urandom_range(0, 5) == 0) begin
                w_left                 = int'(LINE_BEATS);
                io_dcache_w_bits_waddr = ($urandom_range(0, 1) == 0) ? 64'h8000_0100 : rand_line();
                io_dcache_w_bits_wdata = {$urandom, $urandom};
            end
        end
        io_dcache_w_valid      = (w_left > 0);
        io_dcache_w_bits_wlast = (w_left == 1);
        io_mem_r_ready         = ($urandom_range(0, 3) != 0);
        io_mem_w_ready         = ($urandom_range(0, 3) != 0);
        io_dcache_b_ready      = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int n;
        reset                  = 1'b1;
        io_icache_r_valid      = 1'b0;
        io_icache_r_bits_raddr = '0;
        io_dcache_r_valid      = 1'b0;
        io_dcache_r_bits_raddr = '0;
        io_dcache_w_valid      = 1'b0;
        io_dcache_w_bits_waddr = '0;
        io_dcache_w_bits_wdata = '0;
        io_dcache_w_bits_wlast = 1'b0;
        io_dcache_b_ready      = 1'b1;
        io_mem_r_ready         = 1'b1;
        io_mem_w_ready         = 1'b1;
        io_mem_b_valid         = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        // Simultaneous first requests: ICache must win the first tie
        issue(1'b1, 64'h8000_0010);
        issue(1'b0, 64'h8000_0200);

        for (int c = 0; c < RUN_CYCLES; c++) step(1'b1);

        n = 0;
        while (n < DRAIN_MAX && (ic_active || dc_active || b_out > 0 || w_left > 0)) begin
            step(1'b0);
            n++;
        end
        repeat (2) step(1'b0);
        check("drain_icache_queue", 64'(ic_exp.size()), 64'd0);
        check("drain_dcache_queue", 64'(dc_exp.size()), 64'd0);
        check("drain_requests_done", 64'({ic_active, dc_active}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
